seg_scan_mux: RTL and testbench

Time-multiplexed six-digit seven-segment display driver that sits directly downstream of `DigitalClock`. It consumes the six 7-bit segment patterns (seconds, minutes and hours, each as ones and tens) and drives one shared active-low segment bus, one active-low decimal-point line and six active-low digit enables. Digits are scanned one at a time with a blanking gap between them to suppress ghosting. All six inputs are snapshotted once per frame so the displayed time is always self-consistent. A blinking colon is derived from seconds activity.

---
 rtl/seg_scan_mux.sv | 114 +++++++++++
 tb/tb_seg_scan_mux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Six-digit multiplexed seven-segment driver: per-frame input snapshot, blanking gap per slot,
// and a colon that toggles whenever the seconds-ones digit changes between frames.
module seg_scan_mux #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_en,
    input  logic [6:0] sec_ones_seg,
    input  logic [6:0] sec_tens_seg,
    input  logic [6:0] min_ones_seg,
    input  logic [6:0] min_tens_seg,
    input  logic [6:0] hour_ones_seg,
    input  logic [6:0] hour_tens_seg,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] dig_n,
    output logic       colon_on
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [6:0]       r_snap [6];
    logic             r_colon;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [5:0]       r_dig_n;

    logic [CNT_W-1:0] w_cnt_d;
    logic [2:0]       w_idx_d;
    logic [6:0]       w_snap_d [6];
    logic             w_colon_d;
    logic             w_slot_end;
    logic             w_frame_wrap;
    logic             w_lit;
    logic [6:0]       w_seg_n_d;
    logic             w_dp_n_d;
    logic [5:0]       w_dig_n_d;

    always_comb begin
        w_slot_end   = (r_cnt == CNT_LAST);
        w_frame_wrap = w_slot_end && (r_idx == 3'd5);
        w_cnt_d      = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_d      = r_idx;
        if (w_slot_end) begin
            w_idx_d = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end

        for (int i = 0; i < 6; i++) begin
            w_snap_d[i] = r_snap[i];
        end
        w_colon_d = r_colon;
        // Inputs only matter on the frame-wrap edge so a frame never mixes old and new digits.
        if (w_frame_wrap) begin
            w_snap_d[0] = sec_ones_seg;
            w_snap_d[1] = sec_tens_seg;
            w_snap_d[2] = min_ones_seg;
            w_snap_d[3] = min_tens_seg;
            w_snap_d[4] = hour_ones_seg;
            w_snap_d[5] = hour_tens_seg;
            if (sec_ones_seg != r_snap[0]) begin
                w_colon_d = ~r_colon;
            end
        end
    end

    // Outputs are decoded from the next state so the registered outputs match the post-edge state.
    always_comb begin
        w_lit     = display_en && (w_cnt_d >= CNT_BLANK);
        w_seg_n_d = 7'h7F;
        w_dp_n_d  = 1'b1;
        w_dig_n_d = 6'h3F;
        if (w_lit) begin
            w_seg_n_d = ~w_snap_d[w_idx_d];
            w_dig_n_d = ~(6'b000001 << w_idx_d);
            w_dp_n_d  = ~(w_colon_d && ((w_idx_d == 3'd1) || (w_idx_d == 3'd3)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_colon <= 1'b0;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
            r_dig_n <= 6'h3F;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= 7'h00;
            end
        end else begin
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_colon <= w_colon_d;
            r_seg_n <= w_seg_n_d;
            r_dp_n  <= w_dp_n_d;
            r_dig_n <= w_dig_n_d;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= w_snap_d[i];
            end
        end
    end

    assign seg_n    = r_seg_n;
    assign dp_n     = r_dp_n;
    assign dig_n    = r_dig_n;
    assign colon_on = r_colon;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (SCAN_DIV=4, BLANK_CYCLES=1); every edge is checked against
// expectations derived from the edge count since reset.
module tb_seg_scan_mux;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_en = 1'b1;
    logic [6:0] in_seg [6];
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] dig_n;
    logic       colon_on;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_edge = 0;
    logic [6:0] e_snap [6];
    logic       e_colon = 1'b0;
    logic [6:0] ord_seg [6];
    logic [5:0] ord_dig [6];

    seg_scan_mux #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .display_en   (display_en),
        .sec_ones_seg (in_seg[0]),
        .sec_tens_seg (in_seg[1]),
        .min_ones_seg (in_seg[2]),
        .min_tens_seg (in_seg[3]),
        .hour_ones_seg(in_seg[4]),
        .hour_tens_seg(in_seg[5]),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .dig_n        (dig_n),
        .colon_on     (colon_on)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n_edge, got, exp);
        end
    endtask

    // One clock edge; expected outputs follow from edge count, held snapshot and display_en.
    task automatic tick();
        int         cnt;
        int         idx;
        logic       en_s;
        logic       lit;
        logic [6:0] e_seg;
        logic [5:0] e_dig;
        logic       e_dp;
        @(posedge clk);
        en_s = display_en;
        if (reset) begin
            n_edge  = 0;
            e_colon = 1'b0;
            for (int i = 0; i < 6; i++) e_snap[i] = 7'h00;
        end else begin
            n_edge++;
            if (n_edge % FRAME == 0) begin
                if (in_seg[0] != e_snap[0]) e_colon = ~e_colon;
                for (int i = 0; i < 6; i++) e_snap[i] = in_seg[i];
            end
        end
        cnt   = n_edge % SD;
        idx   = (n_edge / SD) % 6;
        lit   = en_s && (cnt >= BC);
        e_seg = lit ? ~e_snap[idx] : 7'h7F;
        e_dig = lit ? ~(6'b000001 << idx) : 6'h3F;
        e_dp  = lit ? ~(e_colon && (idx == 1 || idx == 3)) : 1'b1;
        #1;
        check_eq("dig_n", 32'(dig_n), 32'(e_dig));
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("dp_n", 32'(dp_n), 32'(e_dp));
        check_eq("colon_on", 32'(colon_on), 32'(e_colon));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_to(input int ph);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (n_edge % FRAME == ph) return;
        end
        check_eq("run_to_phase", 32'(n_edge % FRAME), 32'(ph));
    endtask

    task automatic set_all(input logic [6:0] v);
        @(negedge clk);
        for (int i = 0; i < 6; i++) in_seg[i] = v;
    endtask

    initial begin
        logic c_hold;
        ord_seg[0] = 7'h79; ord_seg[1] = 7'h24; ord_seg[2] = 7'h30;
        ord_seg[3] = 7'h19; ord_seg[4] = 7'h12; ord_seg[5] = 7'h02;
        ord_dig[0] = 6'h3E; ord_dig[1] = 6'h3D; ord_dig[2] = 6'h3B;
        ord_dig[3] = 6'h37; ord_dig[4] = 6'h2F; ord_dig[5] = 6'h1F;
        for (int i = 0; i < 6; i++) in_seg[i] = 7'h3F;

        // Reset release with all inputs 7'h3F
        tick();
        check_eq("rst_seg", 32'(seg_n), 32'h7F);
        check_eq("rst_dig", 32'(dig_n), 32'h3F);
        check_eq("rst_dp", 32'(dp_n), 32'h1);
        check_eq("rst_colon", 32'(colon_on), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run(2 * FRAME);

        // Digit ordering
        @(negedge clk);
        in_seg[0] = 7'h06; in_seg[1] = 7'h5B; in_seg[2] = 7'h4F;
        in_seg[3] = 7'h66; in_seg[4] = 7'h6D; in_seg[5] = 7'h7D;
        run_to(0);
        for (int s = 0; s < 6; s++) begin
            run(2);
            check_eq("order_seg", 32'(seg_n), 32'(ord_seg[s]));
            check_eq("order_dig", 32'(dig_n), 32'(ord_dig[s]));
            run(2);
        end

        // Mid-frame change of min_ones during slot 2
        run_to(9);
        @(negedge clk);
        in_seg[2] = 7'h07;
        tick();
        check_eq("midframe_old", 32'(seg_n), 32'h30);
        run_to(10);
        check_eq("midframe_new", 32'(seg_n), 32'h78);

        // One-cycle pulse away from frame wrap
        run_to(16);
        @(negedge clk);
        in_seg[4] = 7'h00;
        tick();
        @(negedge clk);
        in_seg[4] = 7'h6D;
        run_to(0);
        run_to(18);
        check_eq("pulse_ignored", 32'(seg_n), 32'h12);

        // Colon: alternate sec_ones every 3 frames
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_seg[0] = (k % 2 == 0) ? 7'h3F : 7'h06;
            run(3 * FRAME);
        end
        c_hold = colon_on;
        run(3 * FRAME);
        check_eq("colon_hold", 32'(colon_on), 32'(c_hold));

        // display_en low for 10 cycles mid-slot
        run_to(5);
        @(negedge clk);
        display_en = 1'b0;
        run(10);
        @(negedge clk);
        display_en = 1'b1;
        run(30);

        // Reset mid-slot (idx 3, cnt 2), then restart as after first release
        run_to(14);
        set_all(7'h3F);
        reset = 1'b1;
        tick();
        check_eq("rst2_seg", 32'(seg_n), 32'h7F);
        check_eq("rst2_dig", 32'(dig_n), 32'h3F);
        check_eq("rst2_dp", 32'(dp_n), 32'h1);
        check_eq("rst2_colon", 32'(colon_on), 32'h0);
        run(3);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("rst2_first_lit", 32'(dig_n), 32'h3E);
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
